// File: rtl/echo_line_encoder.sv
// Eight-line falling-edge event encoder: synchronizes active-low echo lines,
// queues one pending event per line and presents them lowest-index-first over valid/ready.
module echo_line_encoder #(
    parameter int SYNC_STAGES = 2,
    parameter int ARM_CYCLES  = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] echo_n,
    output logic       out_valid,
    output logic [2:0] out_code,
    input  logic       out_ready,
    output logic [7:0] pending,
    output logic [7:0] overrun,
    input  logic       clear_overrun
);

    localparam int ARM_W = (ARM_CYCLES > 1) ? $clog2(ARM_CYCLES + 1) : 1;

    logic [SYNC_STAGES-1:0][7:0] sync_q;
    logic [7:0]       prev_q;
    logic [ARM_W-1:0] arm_q,     arm_d;
    logic [7:0]       pending_q, pending_d;
    logic [7:0]       overrun_q, overrun_d;
    logic             valid_q,   valid_d;
    logic [2:0]       code_q,    code_d;

    logic [7:0] sync_now;
    logic       armed;
    logic [7:0] fall;
    logic       slot_free;
    logic       load;
    logic [2:0] load_idx;
    logic [7:0] load_mask;

    assign sync_now = sync_q[SYNC_STAGES-1];
    assign armed    = (arm_q == '0);
    assign fall     = armed ? (~sync_now & prev_q) : 8'h00;

    always_comb begin
        load_idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (pending_q[i]) load_idx = 3'(i);
        end
    end

    always_comb begin
        arm_d     = arm_q;
        pending_d = pending_q;
        overrun_d = overrun_q;
        valid_d   = valid_q;
        code_d    = code_q;
        slot_free = ~valid_q | out_ready;
        load      = slot_free & (|pending_q);
        load_mask = load ? (8'h01 << load_idx) : 8'h00;

        if (arm_q != '0) arm_d = arm_q - ARM_W'(1);

        // A fall always wins over the load-clear, so a same-cycle re-fire survives.
        pending_d = fall | (pending_q & ~load_mask);
        overrun_d = (clear_overrun ? 8'h00 : overrun_q) | (fall & pending_q & ~load_mask);

        if (slot_free) begin
            if (load) begin
                valid_d = 1'b1;
                code_d  = load_idx;
            end else begin
                valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q    <= '1;
            prev_q    <= 8'hFF;
            arm_q     <= ARM_W'(ARM_CYCLES);
            pending_q <= 8'h00;
            overrun_q <= 8'h00;
            valid_q   <= 1'b0;
            code_q    <= 3'd0;
        end else begin
            sync_q    <= {sync_q[SYNC_STAGES-2:0], echo_n};
            prev_q    <= sync_now;
            arm_q     <= arm_d;
            pending_q <= pending_d;
            overrun_q <= overrun_d;
            valid_q   <= valid_d;
            code_q    <= code_d;
        end
    end

    assign out_valid = valid_q;
    assign out_code  = code_q;
    assign pending   = pending_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_echo_line_encoder.sv
// Directed bench for echo_line_encoder: each task drives one scenario and checks
// outputs 1 time unit after the rising edge against hand-computed values.
module tb_echo_line_encoder;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] echo_n;
    logic       out_valid;
    logic [2:0] out_code;
    logic       out_ready;
    logic [7:0] pending;
    logic [7:0] overrun;
    logic       clear_overrun;

    int errors = 0;
    int checks = 0;

    echo_line_encoder #(.SYNC_STAGES(2), .ARM_CYCLES(3)) dut (
        .clk           (clk),
        .reset         (reset),
        .echo_n        (echo_n),
        .out_valid     (out_valid),
        .out_code      (out_code),
        .out_ready     (out_ready),
        .pending       (pending),
        .overrun       (overrun),
        .clear_overrun (clear_overrun)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk_state(input string name, input logic exp_valid, input logic [2:0] exp_code,
                             input logic [7:0] exp_pend, input logic [7:0] exp_ovr, input logic use_code);
        checks++;
        if (out_valid !== exp_valid) begin
            errors++;
            $display("FAIL %s out_valid: got %b expected %b", name, out_valid, exp_valid);
        end
        checks++;
        if (pending !== exp_pend) begin
            errors++;
            $display("FAIL %s pending: got %h expected %h", name, pending, exp_pend);
        end
        checks++;
        if (overrun !== exp_ovr) begin
            errors++;
            $display("FAIL %s overrun: got %h expected %h", name, overrun, exp_ovr);
        end
        if (use_code) begin
            checks++;
            if (out_code !== exp_code) begin
                errors++;
                $display("FAIL %s out_code: got %0d expected %0d", name, out_code, exp_code);
            end
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; echo_n = 8'hFF; out_ready = 1'b0; clear_overrun = 1'b0;
        tick(2);
        chk_state("reset_state", 1'b0, 3'd0, 8'h00, 8'h00, 1'b1);
        reset = 1'b0;
        for (int c = 0; c < 10; c++) begin
            tick();
            chk_state("reset_idle", 1'b0, 3'd0, 8'h00, 8'h00, 1'b0);
        end
    endtask

    task automatic test_single;
        out_ready = 1'b1;
        echo_n = 8'hF7;
        tick();                    // E
        tick();                    // E+1
        chk_state("single_e1", 1'b0, 3'd0, 8'h00, 8'h00, 1'b0);
        tick();                    // E+2
        chk_state("single_e2", 1'b0, 3'd0, 8'h08, 8'h00, 1'b0);
        tick();                    // E+3
        chk_state("single_e3", 1'b1, 3'd3, 8'h00, 8'h00, 1'b1);
        tick();                    // E+4
        chk_state("single_e4", 1'b0, 3'd3, 8'h00, 8'h00, 1'b1);
        tick(3);
        chk_state("single_held", 1'b0, 3'd3, 8'h00, 8'h00, 1'b0);
        echo_n = 8'hFF;
        tick(4);
    endtask

    task automatic test_back_to_back;
        out_ready = 1'b0;
        echo_n = 8'hAD;            // lines 6, 4, 1 low
        tick(3);                   // E+2
        chk_state("b2b_pend", 1'b0, 3'd0, 8'h52, 8'h00, 1'b0);
        tick();                    // E+3
        chk_state("b2b_first", 1'b1, 3'd1, 8'h50, 8'h00, 1'b1);
        tick(3);
        chk_state("b2b_stall", 1'b1, 3'd1, 8'h50, 8'h00, 1'b1);
        out_ready = 1'b1;
        tick();
        chk_state("b2b_acc1", 1'b1, 3'd4, 8'h40, 8'h00, 1'b1);
        tick();
        chk_state("b2b_acc2", 1'b1, 3'd6, 8'h00, 8'h00, 1'b1);
        tick();
        chk_state("b2b_acc3", 1'b0, 3'd6, 8'h00, 8'h00, 1'b1);
        out_ready = 1'b0;
        echo_n = 8'hFF;
        tick(4);
    endtask

    task automatic test_overrun;
        out_ready = 1'b0;
        echo_n = 8'hFE;            // line 0 occupies the slot
        tick(4);
        chk_state("ovr_hold0", 1'b1, 3'd0, 8'h00, 8'h00, 1'b1);
        echo_n = 8'hFA;            // line 2 falls
        tick(4);
        chk_state("ovr_first", 1'b1, 3'd0, 8'h04, 8'h00, 1'b1);
        echo_n = 8'hFE;            // line 2 high for 3 cycles
        tick(3);
        chk_state("ovr_rise", 1'b1, 3'd0, 8'h04, 8'h00, 1'b1);
        echo_n = 8'hFA;            // line 2 falls again
        tick(4);
        chk_state("ovr_set", 1'b1, 3'd0, 8'h04, 8'h04, 1'b1);
        tick(2);
        chk_state("ovr_sticky", 1'b1, 3'd0, 8'h04, 8'h04, 1'b1);
        clear_overrun = 1'b1;
        tick();
        clear_overrun = 1'b0;
        chk_state("ovr_clear", 1'b1, 3'd0, 8'h04, 8'h00, 1'b1);
        echo_n = 8'hFF;
        out_ready = 1'b1;
        tick();
        chk_state("ovr_drain1", 1'b1, 3'd2, 8'h00, 8'h00, 1'b1);
        tick();
        chk_state("ovr_drain2", 1'b0, 3'd2, 8'h00, 8'h00, 1'b1);
        out_ready = 1'b0;
        tick(3);
    endtask

    task automatic test_held_low;
        reset = 1'b1; echo_n = 8'h00; out_ready = 1'b0;
        tick(3);
        reset = 1'b0;
        tick(10);
        chk_state("low_armed", 1'b0, 3'd0, 8'h00, 8'h00, 1'b1);
        echo_n = 8'h80;            // line 7 rises
        tick(4);
        chk_state("low_rise", 1'b0, 3'd0, 8'h00, 8'h00, 1'b1);
        echo_n = 8'h00;            // line 7 falls
        tick(3);
        chk_state("low_e2", 1'b0, 3'd0, 8'h80, 8'h00, 1'b0);
        tick();
        chk_state("low_e3", 1'b1, 3'd7, 8'h00, 8'h00, 1'b1);
        out_ready = 1'b1;
        tick();
        chk_state("low_acc", 1'b0, 3'd7, 8'h00, 8'h00, 1'b1);
        tick(4);
        chk_state("low_single", 1'b0, 3'd7, 8'h00, 8'h00, 1'b1);
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid;
        reset = 1'b1; echo_n = 8'hFF;
        tick(2);
        reset = 1'b0;
        tick(6);
        echo_n = 8'hAE;            // lines 6, 4, 0 low
        tick(4);
        chk_state("mid_pre", 1'b1, 3'd0, 8'h50, 8'h00, 1'b1);
        reset = 1'b1;
        tick();
        chk_state("mid_reset", 1'b0, 3'd0, 8'h00, 8'h00, 1'b1);
        reset = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick();
            chk_state("mid_after", 1'b0, 3'd0, 8'h00, 8'h00, 1'b0);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_overrun();
        test_held_low();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
